// File: rtl/tc_mem_arbiter_if.sv
// tc_mem_arbiter_if: request/grant bundle between tensorcores,
// the arbiter and the shared memory transfer engine.
interface tc_mem_arbiter_if #(
  parameter int N     = 4,
  parameter int SEL_W = 3
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N*SEL_W-1:0] req_sel;
  logic [N-1:0]       req_finish;
  logic               mem_req_valid;
  logic [SEL_W-1:0]   mem_req_sel;
  logic [ID_W-1:0]    mem_req_id;
  logic               mem_finish;
  logic               busy;
  logic               err;
  logic [ID_W-1:0]    err_id;

  modport slave (
    input  req_valid, req_sel, mem_finish,
    output req_finish, mem_req_valid, mem_req_sel,
    output mem_req_id, busy, err, err_id
  );

  modport master (
    output req_valid, req_sel, mem_finish,
    input  req_finish, mem_req_valid, mem_req_sel,
    input  mem_req_id, busy, err, err_id
  );
endinterface

// File: rtl/tc_mem_arbiter.sv
// tc_mem_arbiter: round-robin share of one memory transfer
// engine among N tensorcores, with write-back priority and watchdog.
module tc_mem_arbiter #(
  parameter int N       = 4,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 1023,
  parameter int WB_PRIO = 1
) (
  input logic clk,
  input logic rst,
  tc_mem_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N);
  localparam int IW1  = ID_W + 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     set_m, clr_m, wb_m, cand;
  logic [SEL_W-1:0] sel_q [N];
  logic [ID_W-1:0]  rr_q, rr_d, win;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             mrv_d, err_d;
  logic [SEL_W-1:0] msel_d;
  logic [ID_W-1:0]  mid_d, eid_d;
  logic [N-1:0]     fin_d;

  assign bus.busy = (state_q == WAIT);

  // write-back requesters narrow the search when priority is on
  always_comb begin
    for (int i = 0; i < N; i++)
      wb_m[i] = pend_q[i] && (sel_q[i] == '0);
    cand = (WB_PRIO != 0 && |wb_m) ? wb_m : pend_q;
  end

  // first candidate at or after rr_q, wrapping modulo N
  always_comb begin
    logic [IW1-1:0] idx;
    idx = '0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + IW1'(k);
      if (idx >= IW1'(N))
        idx = idx - IW1'(N);
      if (cand[idx[ID_W-1:0]])
        win = idx[ID_W-1:0];
    end
  end

  // a new request wins over a same-cycle completion clear
  always_comb begin
    set_m  = bus.req_valid & (~pend_q | clr_m);
    pend_d = (pend_q & ~clr_m) | set_m;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // grant in IDLE; finish or watchdog abort in WAIT
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    mrv_d   = 1'b0;
    msel_d  = bus.mem_req_sel;
    mid_d   = bus.mem_req_id;
    fin_d   = '0;
    clr_m   = '0;
    err_d   = 1'b0;
    eid_d   = bus.err_id;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          mrv_d   = 1'b1;
          msel_d  = sel_q[win];
          mid_d   = win;
          wd_d    = '0;
          rr_d    = (win == ID_W'(N - 1)) ? '0 : win + 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.mem_finish) begin
          fin_d   = ONE << bus.mem_req_id;
          clr_m   = fin_d;
          state_d = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          fin_d   = ONE << bus.mem_req_id;
          clr_m   = fin_d;
          err_d   = 1'b1;
          eid_d   = bus.mem_req_id;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  // pending/selector storage and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q            <= '0;
      rr_q              <= '0;
      wd_q              <= '0;
      for (int i = 0; i < N; i++)
        sel_q[i]        <= '0;
      bus.req_finish    <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_sel   <= '0;
      bus.mem_req_id    <= '0;
      bus.err           <= 1'b0;
      bus.err_id        <= '0;
    end else begin
      pend_q            <= pend_d;
      rr_q              <= rr_d;
      wd_q              <= wd_d;
      for (int i = 0; i < N; i++)
        if (set_m[i])
          sel_q[i]      <= bus.req_sel[i*SEL_W +: SEL_W];
      bus.req_finish    <= fin_d;
      bus.mem_req_valid <= mrv_d;
      bus.mem_req_sel   <= msel_d;
      bus.mem_req_id    <= mid_d;
      bus.err           <= err_d;
      bus.err_id        <= eid_d;
    end
  end
endmodule

// File: tb/tb_tc_mem_arbiter.sv
// tb_tc_mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural arbiter model.
module tb_tc_mem_arbiter;
  localparam int N       = 4;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int WB_PRIO = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tc_mem_arbiter_if #(.N(N), .SEL_W(SEL_W)) bus ();

  tc_mem_arbiter #(
    .N(N), .SEL_W(SEL_W),
    .TIMEOUT(TIMEOUT), .WB_PRIO(WB_PRIO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  bit               m_pend [N];
  logic [SEL_W-1:0] m_sel  [N];
  int               m_rr     = 0;
  bit               m_wait   = 0;
  int               m_cnt    = 0;
  logic [N-1:0]     m_fin    = '0;
  bit               m_mrv    = 0;
  logic [SEL_W-1:0] m_msel   = '0;
  int               m_id     = 0;
  bit               m_err    = 0;
  int               m_err_id = 0;

  logic [SEL_W-1:0] codes [4] = '{3'b001, 3'b010, 3'b100, 3'b000};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic int pick();
    bit any_wb;
    int j;
    any_wb = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_sel[i] == 3'b000) any_wb = 1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (m_pend[j] &&
          (!(WB_PRIO == 1 && any_wb) || m_sel[j] == 3'b000))
        return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    int clr;
    logic [N-1:0]       rv;
    logic [N*SEL_W-1:0] rs;
    rv = bus.req_valid;
    rs = bus.req_sel;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_sel[i]  = '0;
      end
      m_rr = 0; m_wait = 0; m_cnt = 0;
      m_fin = '0; m_mrv = 0; m_msel = '0;
      m_id = 0; m_err = 0; m_err_id = 0;
    end else begin
      m_fin = '0;
      m_mrv = 0;
      m_err = 0;
      clr   = -1;
      if (m_wait) begin
        if (bus.mem_finish) begin
          m_fin[m_id] = 1'b1;
          clr = m_id;
          m_wait = 0;
        end else if (m_cnt == TIMEOUT - 1) begin
          m_err = 1;
          m_err_id = m_id;
          m_fin[m_id] = 1'b1;
          clr = m_id;
          m_wait = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        w = pick();
        if (w >= 0) begin
          m_mrv  = 1;
          m_msel = m_sel[w];
          m_id   = w;
          m_rr   = (w + 1) % N;
          m_cnt  = 0;
          m_wait = 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rv[i] && (!m_pend[i] || clr == i)) begin
          m_pend[i] = 1;
          m_sel[i]  = rs[i*SEL_W +: SEL_W];
        end else if (clr == i) begin
          m_pend[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("req_finish", bus.req_finish, m_fin);
    chk("mem_req_valid", bus.mem_req_valid, m_mrv);
    chk("mem_req_sel", bus.mem_req_sel, m_msel);
    chk("mem_req_id", bus.mem_req_id, m_id);
    chk("busy", bus.busy, m_wait);
    chk("err", bus.err, m_err);
    chk("err_id", bus.err_id, m_err_id);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input logic [N-1:0] rv,
                        input logic [N*SEL_W-1:0] rs,
                        input logic mf);
    bus.req_valid  = rv;
    bus.req_sel    = rs;
    bus.mem_finish = mf;
  endtask

  initial begin
    set_in('0, '0, 1'b0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("rst_mrv", bus.mem_req_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fin", bus.req_finish, 0);
    rst = 1'b1;
    repeat (2) cycle();

    // single request from requester 2
    set_in(4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("a_mrv", bus.mem_req_valid, 1);
    chk("a_id", bus.mem_req_id, 2);
    chk("a_sel", bus.mem_req_sel, 3'b010);
    chk("a_busy", bus.busy, 1);
    repeat (5) cycle();
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    chk("a_fin", bus.req_finish, 4'b0100);
    chk("a_busy0", bus.busy, 0);
    cycle();

    // write-back of requester 3 beats load A of requester 1
    set_in(4'b1010, {3'b000, 3'b000, 3'b010, 3'b000}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("wb_id", bus.mem_req_id, 3);
    chk("wb_sel", bus.mem_req_sel, 3'b000);
    cycle();
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("wb_mrv2", bus.mem_req_valid, 1);
    chk("wb_id2", bus.mem_req_id, 1);
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();

    // duplicate request while pending is dropped
    set_in(4'b0001, {9'b0, 3'b100}, 1'b0);
    cycle();
    set_in(4'b0001, {9'b0, 3'b010}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    chk("dup_sel", bus.mem_req_sel, 3'b100);
    chk("dup_id", bus.mem_req_id, 0);
    cycle();
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("dup_none", bus.mem_req_valid, 0);

    // request arriving with its own finish is re-latched
    set_in(4'b0010, {6'b0, 3'b001, 3'b000}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("col_id1", bus.mem_req_id, 1);
    set_in(4'b0010, {6'b0, 3'b100, 3'b000}, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    chk("col_fin", bus.req_finish, 4'b0010);
    cycle();
    chk("col_mrv", bus.mem_req_valid, 1);
    chk("col_sel", bus.mem_req_sel, 3'b100);
    chk("col_id", bus.mem_req_id, 1);
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();

    // watchdog abort
    set_in(4'b0100, {3'b000, 3'b001, 6'b0}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("to_mrv", bus.mem_req_valid, 1);
    repeat (7) cycle();
    chk("to_err0", bus.err, 0);
    cycle();
    chk("to_err", bus.err, 1);
    chk("to_eid", bus.err_id, 2);
    chk("to_fin", bus.req_finish, 4'b0100);
    chk("to_busy", bus.busy, 0);
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    chk("late_fin", bus.req_finish, 0);
    chk("late_eid", bus.err_id, 2);
    cycle();

    // finish on the timeout cycle wins
    set_in(4'b0001, {9'b0, 3'b010}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    repeat (7) cycle();
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    chk("tie_err", bus.err, 0);
    chk("tie_fin", bus.req_finish, 4'b0001);
    cycle();

    // reset in the middle of a transfer
    set_in(4'b1000, {3'b010, 9'b0}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_id", bus.mem_req_id, 0);
    chk("mid_sel", bus.mem_req_sel, 0);
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    chk("mid_fin", bus.req_finish, 0);
    cycle();
    chk("mid_mrv", bus.mem_req_valid, 0);

    // round-robin over four simultaneous loads
    set_in(4'b1111, {4{3'b001}}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    for (int k = 0; k < N; k++) begin
      chk("rr_mrv", bus.mem_req_valid, 1);
      chk("rr_id", bus.mem_req_id, k);
      set_in('0, '0, 1'b1);
      cycle();
      set_in('0, '0, 1'b0);
      cycle();
    end
    set_in(4'b0001, {9'b0, 3'b001}, 1'b0);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();
    chk("rr_wrap", bus.mem_req_id, 0);
    set_in('0, '0, 1'b1);
    cycle();
    set_in('0, '0, 1'b0);
    cycle();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0]       rv;
      logic [N*SEL_W-1:0] rs;
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 5) == 0);
        rs[i*SEL_W +: SEL_W] = codes[$urandom_range(0, 3)];
      end
      set_in(rv, rs, $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    rst = 1'b1;
    set_in('0, '0, 1'b0);
    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tc_mem_arbiter.md
# tc_mem_arbiter

Shares one memory transfer engine (the AXI load/store path) among N tensorcore instances. Each tensorcore issues single-cycle transfer requests: load C, load A, load B, or write back. The arbiter latches them, grants round-robin with optional write-back priority, forwards one transfer at a time to the engine, and returns a per-requester finish pulse. A watchdog releases the engine if a transfer never completes.

## Interface
- N, default 4: number of tensorcore requesters (2..16).
- SEL_W, default 3: transfer selector width; 3'b001 C, 3'b010 A, 3'b100 B, 3'b000 write back.
- TIMEOUT, default 1023: maximum cycles in WAIT before abort (≥2).
- WB_PRIO, default 1: 1 = pending write-backs beat pending loads; 0 = pure round-robin.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  N  per-requester request pulse, one cycle.
- req_sel  in  N*SEL_W  selector; requester i uses bits [i*SEL_W +: SEL_W], sampled with req_valid[i].
- req_finish  out  N  one-cycle completion pulse to the granted requester.
- mem_req_valid  out  1  one-cycle transfer start pulse to the engine.
- mem_req_sel  out  SEL_W  selector of the issued transfer, held until the next issue.
- mem_req_id  out  $clog2(N)  granted requester index, held until the next issue.
- mem_finish  in  1  engine completion pulse.
- busy  out  1  high in WAIT.
- err  out  1  one-cycle timeout pulse.
- err_id  out  $clog2(N)  requester whose transfer timed out; valid with err, held afterwards.

## Operation
- Per-requester pending bit plus stored selector.
  - req_valid[i] with pending[i]=0: set pending[i] and store the selector.
  - req_valid[i] with pending[i]=1: drop the request; the stored selector is kept.
  - When pending[i] is cleared in the same cycle req_valid[i] arrives, the set wins and the new selector is stored.
- States: IDLE, WAIT.
- IDLE, with any pending bit visible:
  - choose the winner, register mem_req_valid=1, mem_req_sel and mem_req_id;
  - load the watchdog counter with 0;
  - move to WAIT.
- IDLE with nothing pending: stay in IDLE. A mem_finish arriving in IDLE is ignored.
- Winner selection:
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo N.
  - With WB_PRIO=1 and at least one pending write-back, the search covers only write-back requesters.
  - rr_ptr becomes winner+1 (mod N) at grant.
- WAIT:
  - mem_req_valid returns to 0 after one cycle.
  - The watchdog increments each cycle.
  - On mem_finish: pulse req_finish[mem_req_id], clear pending[mem_req_id], go to IDLE.
  - If the watchdog reaches TIMEOUT-1 before mem_finish: pulse err with err_id=mem_req_id, also pulse req_finish[mem_req_id] so the tensorcore does not hang, clear pending, go to IDLE.
  - When mem_finish and the timeout occur in the same cycle, the finish wins and err is not raised.
- Reset, including mid-transfer:
  - State goes to IDLE; all pending bits, rr_ptr, the watchdog and all outputs are cleared to 0.
  - An engine mem_finish arriving after reset lands in IDLE and is ignored.

## Timing
- Reset values: req_finish=0, mem_req_valid=0, mem_req_sel=0, mem_req_id=0, busy=0, err=0, err_id=0.
- A req_valid in cycle t sets pending at t+1; mem_req_valid is high at t+2 if the arbiter is idle.
- busy is high from the mem_req_valid cycle until the cycle before the arbiter returns to IDLE.
- mem_finish in cycle f:
  - req_finish and the pending clear appear at f+1;
  - the next grant registers in f+1, so the next mem_req_valid is at f+2.
  - Minimum spacing between mem_req_valid pulses is therefore 2 cycles after a finish.
- Timeout: err and req_finish fire TIMEOUT cycles after mem_req_valid if no mem_finish arrives.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single request: reset, then req_valid[2]=1 with sel=3'b010 at t=5 → mem_req_valid, sel=010 and id=2 at t=7; busy at t=7; mem_finish at t=12 → req_finish=4'b0100 at t=13, busy=0.
- Round-robin: N=4 (default), WB_PRIO=0, all four requesters pulse sel=001 together → grants in order 0,1,2,3 with rr_ptr wrapping; a further request from requester 0 is granted after 3.
- Write-back priority: WB_PRIO=1 (default), requester 1 pending load A and requester 3 pending write-back → id=3 granted first; with WB_PRIO=0 and rr_ptr=0 → id=1 first.
- Duplicate and collision: second req_valid[0] while pending is dropped, and the first selector is issued; a req_valid[1] in the same cycle as its finish is re-latched and re-granted.
- Timeout: TIMEOUT=8, no mem_finish → err=1 with err_id equal to the granted id, and req_finish pulsed, 8 cycles after mem_req_valid; a late mem_finish is ignored. Timeout and finish in the same cycle → no err.
- Reset mid-WAIT: assert rst=0 during WAIT → all outputs 0 next cycle and pending cleared; a subsequent mem_finish produces no req_finish.
